// File: rtl/cdb_broadcaster_pkg.sv
// cdb_broadcaster_pkg: shared defaults, constants and types for the common
// data bus broadcaster and the reservation-station tag matchers.
package cdb_broadcaster_pkg;

  localparam int CDB_DATA_W   = 32;
  localparam int CDB_ROB_ID_W = 4;
  localparam int CDB_NUM_SRC  = 4;

  localparam logic [CDB_DATA_W-1:0] ZERO_WORD = '0;

  // ROB tag as seen by the reservation-station matchers
  typedef logic [CDB_ROB_ID_W-1:0] rob_tag_t;

  // Index width that stays legal for a single-element range
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: single-source result queue. Head is visible combinationally
// so the arbiter can pick it in the same cycle; flush empties the queue.
module cdb_src_fifo
  import cdb_broadcaster_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr_reg];

  // Entry storage: written on an accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers and occupancy; flush drops everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: queues results from NUM_SRC producers and broadcasts up
// to two per cycle on two registered CDB lanes.
// Build option: define CDB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority with source 0 highest.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int DATA_W     = CDB_DATA_W,
  parameter int ROB_ID_W   = CDB_ROB_ID_W,
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*ROB_ID_W-1:0]  src_rob_id,
  input  logic [NUM_SRC*DATA_W-1:0]    src_value,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic                         cdb_valid1,
  output logic [ROB_ID_W-1:0]          cdb_rob_id1,
  output logic [DATA_W-1:0]            cdb_value1,
  output logic                         cdb_valid2,
  output logic [ROB_ID_W-1:0]          cdb_rob_id2,
  output logic [DATA_W-1:0]            cdb_value2
);

  localparam int ENT_W = ROB_ID_W + DATA_W;
  localparam int SRC_W = idx_width(NUM_SRC);

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [ENT_W-1:0]   head [NUM_SRC];

  logic               sel1_valid;
  logic               sel2_valid;
  logic [SRC_W-1:0]   sel1_idx;
  logic [SRC_W-1:0]   sel2_idx;
  logic [SRC_W-1:0]   start_idx;
  logic [ENT_W-1:0]   lane1_ent;
  logic [ENT_W-1:0]   lane2_ent;

  // One queue per producer; ready depends on occupancy only
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_ready[gi] = ~full[gi];
      assign push[gi]      = src_valid[gi] & ~full[gi] & ~flush;

      cdb_src_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push[gi]),
        .pop   (pop[gi]),
        .din   ({src_rob_id[gi*ROB_ID_W +: ROB_ID_W], src_value[gi*DATA_W +: DATA_W]}),
        .full  (full[gi]),
        .empty (empty[gi]),
        .head  (head[gi])
      );
    end
  endgenerate

`ifdef CDB_ROUND_ROBIN_EN
  logic [SRC_W-1:0] ptr_reg;
  logic [SRC_W-1:0] last_idx;

  assign start_idx = ptr_reg;
  assign last_idx  = sel2_valid ? sel2_idx : sel1_idx;

  // Round-robin pointer moves past the last granted source; idle or flush holds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (!flush && sel1_valid) begin
      ptr_reg <= (last_idx == SRC_W'(NUM_SRC - 1)) ? '0 : last_idx + SRC_W'(1);
    end
  end
`else
  assign start_idx = '0;
`endif

  // Scan sources from start_idx; first non-empty head to lane 1, second to lane 2
  always_comb begin : arb
    int               cand;
    logic [SRC_W-1:0] cand_idx;
    sel1_valid = 1'b0;
    sel2_valid = 1'b0;
    sel1_idx   = '0;
    sel2_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = int'(start_idx) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      cand_idx = SRC_W'(cand);
      if (!empty[cand_idx]) begin
        if (!sel1_valid) begin
          sel1_valid = 1'b1;
          sel1_idx   = cand_idx;
        end else if (!sel2_valid) begin
          sel2_valid = 1'b1;
          sel2_idx   = cand_idx;
        end
      end
    end
  end

  // Pop the granted heads and pick the lane payloads; unused lanes carry zero
  always_comb begin
    pop       = '0;
    lane1_ent = '0;
    lane2_ent = '0;
    if (sel1_valid) lane1_ent = head[sel1_idx];
    if (sel2_valid) lane2_ent = head[sel2_idx];
    if (!flush) begin
      if (sel1_valid) pop[sel1_idx] = 1'b1;
      if (sel2_valid) pop[sel2_idx] = 1'b1;
    end
  end

  // Registered broadcast lanes; reset and flush clear valid and payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid1  <= 1'b0;
      cdb_rob_id1 <= '0;
      cdb_value1  <= DATA_W'(ZERO_WORD);
      cdb_valid2  <= 1'b0;
      cdb_rob_id2 <= '0;
      cdb_value2  <= DATA_W'(ZERO_WORD);
    end else if (flush) begin
      cdb_valid1  <= 1'b0;
      cdb_rob_id1 <= '0;
      cdb_value1  <= DATA_W'(ZERO_WORD);
      cdb_valid2  <= 1'b0;
      cdb_rob_id2 <= '0;
      cdb_value2  <= DATA_W'(ZERO_WORD);
    end else begin
      cdb_valid1                <= sel1_valid;
      {cdb_rob_id1, cdb_value1} <= lane1_ent;
      cdb_valid2                <= sel2_valid;
      {cdb_rob_id2, cdb_value2} <= lane2_ent;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster: directed checks of latency, pairing, back-pressure,
// flush and reset, with a per-source ordering scoreboard on both lanes.
module tb_cdb_broadcaster;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [NS-1:0]     src_valid;
  logic [NS*RW-1:0]  src_rob_id;
  logic [NS*DW-1:0]  src_value;
  logic [NS-1:0]     src_ready;
  logic              cdb_valid1;
  logic [RW-1:0]     cdb_rob_id1;
  logic [DW-1:0]     cdb_value1;
  logic              cdb_valid2;
  logic [RW-1:0]     cdb_rob_id2;
  logic [DW-1:0]     cdb_value2;

  int errors = 0;
  int checks = 0;

  // Expected queue contents per source, {rob_id, value}; value[11:8] = source
  logic [RW+DW-1:0] exp_q [NS][$];
  int  seq [NS];
  bit  auto_drv;
  int  lane_src1;
  int  lane_src2;

  always #5 clk = ~clk;

  cdb_broadcaster dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .src_valid   (src_valid),
    .src_rob_id  (src_rob_id),
    .src_value   (src_value),
    .src_ready   (src_ready),
    .cdb_valid1  (cdb_valid1),
    .cdb_rob_id1 (cdb_rob_id1),
    .cdb_value1  (cdb_value1),
    .cdb_valid2  (cdb_valid2),
    .cdb_rob_id2 (cdb_rob_id2),
    .cdb_value2  (cdb_value2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src(input int i, input logic [RW-1:0] rob, input logic [DW-1:0] val);
    src_valid[i]            = 1'b1;
    src_rob_id[i*RW +: RW]  = rob;
    src_value[i*DW +: DW]   = val;
  endtask

  task automatic drive_auto(input int i);
    drive_src(i, RW'(seq[i]), DW'(i * 256 + seq[i]));
  endtask

  task automatic clear_sb();
    for (int i = 0; i < NS; i++) exp_q[i].delete();
  endtask

  task automatic observe_lane(input string name, input logic v, input logic [RW-1:0] rob,
                              input logic [DW-1:0] val, output int s);
    logic [RW+DW-1:0] want;
    s = -1;
    if (!v) begin
      check({name, "_idle_zero"}, {rob, val}, '0);
      return;
    end
    check({name, "_src_field"}, (int'(val[11:8]) < NS), 1'b1);
    if (int'(val[11:8]) >= NS) return;
    s = int'(val[11:8]);
    check({name, "_not_stale"}, (exp_q[s].size() != 0), 1'b1);
    if (exp_q[s].size() == 0) return;
    want = exp_q[s].pop_front();
    check({name, "_order"}, {rob, val}, want);
  endtask

  // Record handshakes for the coming edge, advance a clock, then check lanes
  task automatic tick();
    bit pushed [NS];
    for (int i = 0; i < NS; i++) pushed[i] = 1'b0;
    if (rst_n) begin
      if (flush) begin
        clear_sb();
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (src_valid[i] && src_ready[i]) begin
            exp_q[i].push_back({src_rob_id[i*RW +: RW], src_value[i*DW +: DW]});
            pushed[i] = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    lane_src1 = -1;
    lane_src2 = -1;
    if (rst_n) begin
      observe_lane("lane1", cdb_valid1, cdb_rob_id1, cdb_value1, lane_src1);
      observe_lane("lane2", cdb_valid2, cdb_rob_id2, cdb_value2, lane_src2);
      check("lane2_implies_lane1", (cdb_valid2 && !cdb_valid1), 1'b0);
      if (cdb_valid1 && cdb_valid2) check("distinct_src", (lane_src1 == lane_src2), 1'b0);
    end
    if (auto_drv) begin
      for (int i = 0; i < NS; i++) begin
        if (pushed[i]) begin
          seq[i]++;
          drive_auto(i);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    auto_drv  = 1'b0;
    clear_sb();
    for (int i = 0; i < NS; i++) seq[i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_pair(input string tag, input int s1, input int s2);
    check({tag, "_lane1_src"}, lane_src1, s1);
    check({tag, "_lane2_src"}, lane_src2, s2);
  endtask

  task automatic check_noloss(input string tag);
    for (int i = 0; i < NS; i++) check($sformatf("%s_noloss_src%0d", tag, i), exp_q[i].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    src_valid  = '0;
    src_rob_id = '0;
    src_value  = '0;
    auto_drv   = 1'b0;
    for (int i = 0; i < NS; i++) seq[i] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid1", cdb_valid1, 1'b0);
    check("rst_valid2", cdb_valid2, 1'b0);
    check("rst_lane1_data", {cdb_rob_id1, cdb_value1}, '0);
    check("rst_lane2_data", {cdb_rob_id2, cdb_value2}, '0);
    check("rst_ready", src_ready, 4'hF);
    rst_n = 1'b1;

    // Single result, latency 2
    drive_src(0, 4'd3, 32'h11);
    tick();
    src_valid = '0;
    check("t1_not_yet", cdb_valid1, 1'b0);
    tick();
    check("t1_lane1_valid", cdb_valid1, 1'b1);
    check("t1_lane1_tag", cdb_rob_id1, 4'd3);
    check("t1_lane1_value", cdb_value1, 32'h11);
    check("t1_lane2_valid", cdb_valid2, 1'b0);
    tick();
    check("t1_drained", cdb_valid1, 1'b0);

    // Three sources at once: two lanes, then the third
    do_reset();
    drive_src(0, 4'd1, 32'h001);
    drive_src(1, 4'd2, 32'h102);
    drive_src(2, 4'd5, 32'h205);
    tick();
    src_valid = '0;
    tick();
    check("t2_c1_valid1", cdb_valid1, 1'b1);
    check("t2_c1_tag1", cdb_rob_id1, 4'd1);
    check("t2_c1_valid2", cdb_valid2, 1'b1);
    check("t2_c1_tag2", cdb_rob_id2, 4'd2);
    tick();
    check("t2_c2_valid1", cdb_valid1, 1'b1);
    check("t2_c2_tag1", cdb_rob_id1, 4'd5);
    check("t2_c2_valid2", cdb_valid2, 1'b0);
    tick();
    check("t2_c3_idle", cdb_valid1, 1'b0);
    check_noloss("t2");

    // Back-pressure on src3 while src0/src1 keep the lanes busy
    do_reset();
    auto_drv = 1'b1;
    drive_auto(0);
    drive_auto(1);
    drive_auto(3);
    check("t3_ready3_c0", src_ready[3], 1'b1);
    tick();
    check("t3_ready3_c1", src_ready[3], 1'b1);
    tick();
    check("t3_ready3_c2", src_ready[3], 1'b0);
    tick();
    tick();
    src_valid = '0;
    auto_drv  = 1'b0;
    repeat (6) tick();
    check("t3_src3_seen", (seq[3] >= 2), 1'b1);
    check_noloss("t3");

    // All four sources continuously valid: grant pairing
    do_reset();
    auto_drv = 1'b1;
    for (int i = 0; i < NS; i++) drive_auto(i);
    tick();
    tick();
    check_pair("t4_c1", 0, 1);
    tick();
`ifdef CDB_ROUND_ROBIN_EN
    check_pair("t4_c2", 2, 3);
`else
    check_pair("t4_c2", 0, 1);
`endif
    tick();
    check_pair("t4_c3", 0, 1);
    src_valid = '0;
    auto_drv  = 1'b0;
    tick();
`ifdef CDB_ROUND_ROBIN_EN
    check_pair("t4_c4", 2, 3);
`else
    check_pair("t4_c4", 0, 1);
`endif
    tick();
`ifdef CDB_ROUND_ROBIN_EN
    check_pair("t4_c5", 0, 1);
`else
    check_pair("t4_c5", 2, 3);
`endif
    repeat (4) tick();
    check_noloss("t4");

    // Flush with three entries queued; pushes in the flush cycle are dropped
    do_reset();
    auto_drv = 1'b1;
    for (int i = 0; i < NS; i++) drive_auto(i);
    tick();
    src_valid = 4'b0001;
    tick();
    auto_drv = 1'b0;
    check("t5_queued", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 3);
    flush = 1'b1;
    for (int i = 0; i < NS; i++) drive_src(i, 4'hE, DW'(i * 256 + 8'hEE));
    check("t5_ready_in_flush", src_ready, 4'hF);
    tick();
    flush     = 1'b0;
    src_valid = '0;
    check("t5_valid1", cdb_valid1, 1'b0);
    check("t5_valid2", cdb_valid2, 1'b0);
    check("t5_ready_after", src_ready, 4'hF);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("t5_no_stale_c%0d", c), cdb_valid1, 1'b0);
    end

    // Asynchronous reset in the middle of a burst
    do_reset();
    auto_drv = 1'b1;
    for (int i = 0; i < NS; i++) drive_auto(i);
    repeat (3) tick();
    check("t6_busy", cdb_valid1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid1", cdb_valid1, 1'b0);
    check("t6_async_valid2", cdb_valid2, 1'b0);
    check("t6_async_data1", {cdb_rob_id1, cdb_value1}, '0);
    check("t6_async_data2", {cdb_rob_id2, cdb_value2}, '0);
    check("t6_async_ready", src_ready, 4'hF);
    src_valid = '0;
    auto_drv  = 1'b0;
    clear_sb();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_src(2, 4'd9, 32'h209);
    tick();
    src_valid = '0;
    check("t6_not_yet", cdb_valid1, 1'b0);
    tick();
    check("t6_lane1_valid", cdb_valid1, 1'b1);
    check("t6_lane1_tag", cdb_rob_id1, 4'd9);
    check("t6_lane1_value", cdb_value1, 32'h209);
    check("t6_lane2_valid", cdb_valid2, 1'b0);
    tick();
    check_noloss("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
